// File: rtl/sort_ctrl_pkg.sv
// Shared types and widths for the classification-network frame scheduler.
package sort_ctrl_pkg;

  localparam int PIX_W  = 24;
  localparam int ADDR_W = 10;
  localparam int CLS_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_OUT   = 3'd3,
    ST_REL   = 3'd4
  } sched_state_t;

  // One-hot release mask for the served buffer.
  function automatic logic [1:0] buf_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on contention the buffer not served last wins.
module rr_arb2
  import sort_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick a requester, alternating on contention.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_idx   = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sort_net_sched.sv
// Shares one classification network between two ping-pong frame buffers:
// arbitrates, sequences conv_start, watches for timeout and hands the class result out.
module sort_net_sched
  import sort_ctrl_pkg::*;
#(
  parameter int START_HOLD     = 100,
  parameter int TIMEOUT_CYCLES = 1000000
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        done,
  input  logic [PIX_W-1:0]  buf0_data,
  input  logic [PIX_W-1:0]  buf1_data,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [PIX_W-1:0]  net_d_in,
  output logic              net_conv_start,
  input  logic [ADDR_W-1:0] net_read_addr,
  input  logic [CLS_W-1:0]  net_out,
  input  logic              net_complete,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CLS_W-1:0]  res_class,
  output logic              res_src,
  output logic              timeout_err
);

  localparam int HW = $clog2(START_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  sched_state_t  state_r;
  logic          grant_r;
  logic          last_r;
  logic [HW-1:0] hold_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic          complete_q_r;
  logic          complete_rise_s;
  logic          gnt_valid_s;
  logic          gnt_idx_s;

  rr_arb2 u_arb (
    .req       (req),
    .last      (last_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // The network reads pixels straight from the granted buffer with no added latency.
  assign buf_addr        = net_read_addr;
  assign net_d_in        = grant_r ? buf1_data : buf0_data;
  assign complete_rise_s = net_complete & ~complete_q_r;

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      grant_r        <= 1'b0;
      last_r         <= 1'b1;
      hold_cnt_r     <= '0;
      to_cnt_r       <= '0;
      complete_q_r   <= 1'b0;
      net_conv_start <= 1'b0;
      done           <= 2'b00;
      res_valid      <= 1'b0;
      res_class      <= '0;
      res_src        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      complete_q_r <= net_complete;
      case (state_r)
        ST_IDLE: begin
          hold_cnt_r  <= '0;
          to_cnt_r    <= '0;
          done        <= 2'b00;
          timeout_err <= 1'b0;
          if (gnt_valid_s) begin
            grant_r        <= gnt_idx_s;
            net_conv_start <= 1'b1;
            state_r        <= ST_START;
          end
        end
        ST_START, ST_RUN: begin
          // A completion edge wins over a watchdog expiry in the same cycle.
          if (complete_rise_s) begin
            res_class      <= net_out;
            res_src        <= grant_r;
            res_valid      <= 1'b1;
            net_conv_start <= 1'b0;
            state_r        <= ST_OUT;
          end else if (to_cnt_r == TO_LAST) begin
            timeout_err    <= 1'b1;
            done           <= buf_mask(grant_r);
            last_r         <= grant_r;
            net_conv_start <= 1'b0;
            state_r        <= ST_REL;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
            if (state_r == ST_START) begin
              if (hold_cnt_r == HOLD_LAST) begin
                net_conv_start <= 1'b0;
                state_r        <= ST_RUN;
              end else begin
                hold_cnt_r <= hold_cnt_r + 1'b1;
              end
            end
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            last_r    <= grant_r;
            done      <= buf_mask(grant_r);
            state_r   <= ST_REL;
          end
        end
        ST_REL: begin
          // Requests are ignored here so the released buffer has time to drop req.
          done        <= 2'b00;
          timeout_err <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_net_sched.sv
// Directed bench for sort_net_sched with a frame-level reference model compared every cycle.
module tb_sort_net_sched;
  localparam int H  = 4;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  done;
  logic [23:0] buf0_data, buf1_data, net_d_in;
  logic [9:0]  buf_addr, net_read_addr;
  logic        net_conv_start, net_complete, res_valid, res_ready, res_src, timeout_err;
  logic [7:0]  net_out, res_class;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  int hi;
  int n;

  sort_net_sched #(.START_HOLD(H), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .buf0_data(buf0_data), .buf1_data(buf1_data), .buf_addr(buf_addr),
    .net_d_in(net_d_in), .net_conv_start(net_conv_start),
    .net_read_addr(net_read_addr), .net_out(net_out), .net_complete(net_complete),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_src(res_src), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: a frame is busy for at most TO cycles, start is high for its first H.
  logic       m_busy, m_hold, m_rel, m_grant, m_last, m_cq;
  int         m_age;
  logic       e_start, e_valid, e_src, e_to;
  logic [1:0] e_done;
  logic [7:0] e_class;
  wire        m_rise = net_complete && !m_cq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_hold <= 1'b0; m_rel <= 1'b0; m_grant <= 1'b0; m_last <= 1'b1;
      m_cq <= 1'b0; m_age <= 0; e_start <= 1'b0; e_valid <= 1'b0; e_src <= 1'b0;
      e_to <= 1'b0; e_done <= 2'b00; e_class <= 8'h00;
    end else begin
      m_cq <= net_complete;
      if (m_rel) begin
        m_rel <= 1'b0; e_done <= 2'b00; e_to <= 1'b0;
      end else if (m_busy) begin
        if (m_rise) begin
          e_valid <= 1'b1; e_class <= net_out; e_src <= m_grant; e_start <= 1'b0;
          m_busy <= 1'b0; m_hold <= 1'b1;
        end else if (m_age == TO - 1) begin
          e_to <= 1'b1; e_done <= m_grant ? 2'b10 : 2'b01; m_last <= m_grant;
          e_start <= 1'b0; m_busy <= 1'b0; m_rel <= 1'b1;
        end else begin
          m_age <= m_age + 1; e_start <= (m_age + 1 < H);
        end
      end else if (m_hold) begin
        if (res_ready) begin
          e_valid <= 1'b0; m_last <= m_grant; e_done <= m_grant ? 2'b10 : 2'b01;
          m_hold <= 1'b0; m_rel <= 1'b1;
        end
      end else if (req != 2'b00) begin
        m_grant <= (req == 2'b11) ? !m_last : req[1];
        m_busy <= 1'b1; m_age <= 0; e_start <= 1'b1;
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("conv_start", net_conv_start, e_start);
      chk("done", done, e_done);
      chk("res_valid", res_valid, e_valid);
      chk("res_class", res_class, e_class);
      chk("res_src", res_src, e_src);
      chk("timeout_err", timeout_err, e_to);
      chk("net_d_in", net_d_in, m_grant ? buf1_data : buf0_data);
      chk("buf_addr", buf_addr, net_read_addr);
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!net_conv_start && k < 200) begin step(1); k++; end
    chk("start_seen", net_conv_start, 1'b1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!res_valid && k < 200) begin step(1); k++; end
    chk("valid_seen", res_valid, 1'b1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done == 2'b00 && k < 200) begin step(1); k++; end
    chk("done_seen", {31'd0, done != 2'b00}, 32'd1);
  endtask

  // Run one frame: complete dly cycles after start, hand the result out, release.
  task automatic do_frame(input int dly, input logic [7:0] cls, input logic src,
                          input bit keep, output int highs);
    highs = 0;
    wait_start();
    chk("frame_d_in", net_d_in, src ? 24'h000002 : 24'h000001);
    for (int i = 0; i < dly; i++) begin
      if (net_conv_start) highs++;
      step(1);
    end
    net_complete = 1'b1;
    net_out      = cls;
    wait_valid();
    chk("frame_class", res_class, cls);
    chk("frame_src", res_src, src);
    chk("start_low_at_valid", net_conv_start, 1'b0);
    wait_done();
    chk("frame_done", done, src ? 2'b10 : 2'b01);
    net_complete = 1'b0;
    req[src]     = 1'b0;
    step(1);
    chk("done_one_cycle", done, 2'b00);
    if (keep) req[src] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; buf0_data = 24'h000001; buf1_data = 24'h000002;
    net_read_addr = 10'h155; net_out = 8'h00; net_complete = 1'b0; res_ready = 1'b1;
    step(1);
    cmp_en = 1'b1;
    step(2);
    chk("rst_conv_start", net_conv_start, 1'b0);
    chk("rst_done", done, 2'b00);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_class", res_class, 8'h00);
    chk("rst_to", timeout_err, 1'b0);
    rst = 1'b0;

    // Single frame from buffer 0.
    req = 2'b01;
    do_frame(20, 8'd3, 1'b0, 1'b0, hi);
    chk("start_hold_cycles", hi, 4);
    net_read_addr = 10'h2a7;

    // Round robin with both buffers requesting.
    rst = 1'b1; step(2); rst = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      do_frame(6, 8'h10 + 8'(i), 1'(i), i < 3, hi);
    end
    req = 2'b00;

    // Back-pressure holds the result and blocks the next frame.
    req = 2'b11; res_ready = 1'b0;
    wait_start();
    chk("bp_d_in", net_d_in, 24'h000001);
    step(6);
    net_complete = 1'b1; net_out = 8'hA5;
    wait_valid();
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_class", res_class, 8'hA5);
      chk("bp_no_start", net_conv_start, 1'b0);
    end
    res_ready = 1'b1;
    wait_done();
    chk("bp_done", done, 2'b01);
    req[0] = 1'b0; net_complete = 1'b0;
    n = 0;
    while (!net_conv_start && n < 20) begin step(1); n++; end
    chk("bp_next_start_delay", n, 2);
    do_frame(5, 8'h44, 1'b1, 1'b0, hi);

    // Watchdog abandons a frame that never completes.
    req = 2'b11;
    wait_start();
    chk("to_d_in", net_d_in, 24'h000001);
    n = 0;
    while (!timeout_err && n < 200) begin step(1); n++; end
    chk("to_cycles", n, 64);
    chk("to_done", done, 2'b01);
    chk("to_no_valid", res_valid, 1'b0);
    req[0] = 1'b0;
    step(1);
    req[0] = 1'b1;
    do_frame(5, 8'h55, 1'b1, 1'b0, hi);
    req = 2'b00;

    // Completion during START cuts the start pulse short.
    req = 2'b01;
    do_frame(2, 8'h77, 1'b0, 1'b0, hi);
    req = 2'b00;

    // Reset mid-frame clears everything; buffer 0 wins afterwards.
    req = 2'b11;
    wait_start();
    chk("mr_d_in", net_d_in, 24'h000002);
    step(6);
    rst = 1'b1;
    #1;
    chk("mr_conv_start", net_conv_start, 1'b0);
    chk("mr_done", done, 2'b00);
    chk("mr_valid", res_valid, 1'b0);
    chk("mr_src", res_src, 1'b0);
    chk("mr_d_in_after", net_d_in, 24'h000001);
    step(2);
    chk("mr_no_release", done, 2'b00);
    rst = 1'b0;
    do_frame(5, 8'h99, 1'b0, 1'b0, hi);
    req = 2'b00;

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_net_sched.md
# sort_net_sched

Frame scheduler that shares the single GarbageSortTop classification network between two ping-pong pixel frame buffers. It arbitrates round-robin between buffer requests and muxes the granted buffer's pixel word onto the network's `d_in`. It sequences `conv_start`, waits for `net_complete` under a timeout watchdog, and presents the 8-bit class result on a valid/ready port before releasing the buffer.

## Interface
Parameters:
- `START_HOLD`, default 100: cycles `net_conv_start` is held high per frame; must be ≥1.
- `TIMEOUT_CYCLES`, default 1000000: cycles from entering START until the frame is abandoned.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `req`  in  2  per-buffer frame-ready level; held until that buffer's `done` bit pulses.
- `done`  out  2  one-cycle release pulse to the served buffer.
- `buf0_data`, `buf1_data`  in  24  RGB pixel from each buffer at `buf_addr`.
- `buf_addr`  out  10  equals `net_read_addr` (pass-through, combinational).
- `net_d_in`  out  24  `grant ? buf1_data : buf0_data` (combinational).
- `net_conv_start`  out  1  network start, registered.
- `net_read_addr`  in  10  pixel address driven by the network.
- `net_out`  in  8  network class result.
- `net_complete`  in  1  network done level.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_class`  out  8  captured `net_out`.
- `res_src`  out  1  buffer index the result came from.
- `timeout_err`  out  1  one-cycle pulse when a frame is abandoned.

## Operation
- States: IDLE, START, RUN, OUT, REL.
- Priority pointer `last` holds the index of the last-served buffer; reset value 1, so buffer 0 wins first.
- IDLE: if any `req` bit is set, grant it. If both are set, grant `!last`. Latch `grant`, clear the timeout counter, then go to START.
- START: `net_conv_start`=1 for exactly START_HOLD cycles, then go to RUN.
- RUN: `net_conv_start`=0. Wait for a rising edge of `net_complete`, detected against a registered copy whose reset value is 0.
- Completion edge, valid in START or RUN: capture `net_out` into `res_class`, set `res_src` = `grant`, go to OUT. A START that ends early in this way drops `net_conv_start` in the same transition.
- OUT: `res_valid`=1 and held stable until `res_valid & res_ready`; then `last` ← `grant` and go to REL. No new frame starts while OUT is occupied; back-pressure stalls the buffers.
- Timeout: the counter runs in START and RUN. When it reaches TIMEOUT_CYCLES−1 without a completion edge, pulse `timeout_err`, set `last` ← `grant`, and go to REL. No result is produced.
- REL: `done[grant]`=1 for one cycle, then go to IDLE. Requests are not sampled in REL, which guarantees the released buffer has dropped `req`.
- Counter widths: `$clog2(START_HOLD+1)` and `$clog2(TIMEOUT_CYCLES+1)`. No wrap is possible because both counters are cleared on entry to IDLE.
- Reset, at any time including mid-frame: state=IDLE; all registered outputs 0 (`net_conv_start`, `done`, `res_valid`, `res_class`, `res_src`, `timeout_err`); `grant`=0; `last`=1; the aborted frame is not released.

## Timing
- `req` sampled in IDLE at edge N → `net_conv_start` high from N+1 through N+START_HOLD.
- Completion edge sampled at edge M → `res_valid` high from M+1.
- Handshake at edge K → `done` high during cycle K+1. The earliest next grant is sampled at K+2, so `net_conv_start` can rise at K+3.
- `net_d_in` and `buf_addr` are combinational, adding zero latency on the network's read path. `grant` changes only on leaving IDLE.

## Structure
- Package `sort_ctrl_pkg`: state enum, `PIX_W`=24, `ADDR_W`=10, `CLS_W`=8.
- Sub-module `rr_arb2`: two-requester round-robin arbiter (`req`, `last` → `gnt_valid`, `gnt_idx`).
- Everything else lives in the top FSM.

## Test plan
- Single frame: `req`=01, START_HOLD=4, network completes 20 cycles after start with `net_out`=8'd3 → `net_conv_start` high 4 cycles; `res_class`=3, `res_src`=0; `done`=01 one cycle after the handshake.
- Round-robin: both `req` bits held, 4 frames → grants in order 0,1,0,1; the `net_d_in` mux follows `grant` (drive `buf0_data`=24'h1, `buf1_data`=24'h2).
- Back-pressure: `res_ready`=0 for 50 cycles → `res_valid`/`res_class` stable and no second `net_conv_start`; release `res_ready` → `done` pulses, next frame starts 2 cycles later.
- Timeout: TIMEOUT_CYCLES=64, `net_complete` never rises → `timeout_err` and `done` pulse at cycle 64 after START entry, `res_valid` stays 0, and the other buffer is served next.
- Early completion: `net_complete` rises during START → `net_conv_start` drops next cycle and the result is captured.
- Mid-frame reset: assert `rst` during RUN → all outputs 0 immediately, `done` not pulsed; after release, buffer 0 wins the first grant when both `req` bits are set.
